// File: rtl/game_ctrl_if.sv
// game_ctrl_if: groups the pixel/button inputs and the game status outputs of game_ctrl.
//   btnC_debounced      start/restart button level, already debounced
//   pixel_index         current OLED pixel, 0..6143
//   is_player_hitbox    current pixel inside player hitbox
//   is_obstacle         current pixel inside any obstacle
//   oled_data_player    player layer RGB565, 0 = transparent
//   oled_data_obstacle  obstacle layer RGB565, 0 = transparent
//   oled_data_hud       HUD/background RGB565, always opaque
//   game_active         high only while the game is running
//   state               IDLE=0, COUNTDOWN=1, ACTIVE=2, HIT=3, GAME_OVER=4
//   lives               remaining lives
//   countdown           seconds remaining in COUNTDOWN, else 0
//   hit_pulse           one-cycle pulse on each accepted hit
//   oled_data           arbitrated pixel to the OLED driver
// slave is the game_ctrl side, master is the environment driving it.
interface game_ctrl_if;
  logic        btnC_debounced;
  logic [12:0] pixel_index;
  logic        is_player_hitbox;
  logic        is_obstacle;
  logic [15:0] oled_data_player;
  logic [15:0] oled_data_obstacle;
  logic [15:0] oled_data_hud;
  logic        game_active;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [1:0]  countdown;
  logic        hit_pulse;
  logic [15:0] oled_data;

  modport slave (
    input  btnC_debounced, pixel_index, is_player_hitbox, is_obstacle,
    input  oled_data_player, oled_data_obstacle, oled_data_hud,
    output game_active, state, lives, countdown, hit_pulse, oled_data
  );

  modport master (
    output btnC_debounced, pixel_index, is_player_hitbox, is_obstacle,
    output oled_data_player, oled_data_obstacle, oled_data_hud,
    input  game_active, state, lives, countdown, hit_pulse, oled_data
  );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game-level sequencer and OLED layer arbiter.
// Runs the start countdown, detects per-frame player/obstacle collisions, manages lives and
// the post-hit freeze with player blink, and muxes player/obstacle/HUD layers onto oled_data.
// Ports:
//   i_clock_100mhz  system clock
//   i_reset_n       synchronous active-low reset
//   bus             game_ctrl_if.slave (inputs from pixel generators, status/pixel outputs)
module game_ctrl #(
  parameter int unsigned TICKS_PER_SEC  = 100_000_000,
  parameter int unsigned COUNTDOWN_SEC  = 3,
  parameter int unsigned HIT_FREEZE_SEC = 2,
  parameter int unsigned FLASH_TICKS    = TICKS_PER_SEC / 4,
  parameter int unsigned LIVES_INIT     = 3
) (
  input logic         i_clock_100mhz,
  input logic         i_reset_n,
  game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCountdown = 3'd1,
    StActive    = 3'd2,
    StHit       = 3'd3,
    StGameOver  = 3'd4
  } state_e;

  localparam logic [31:0] TickLast   = 32'(TICKS_PER_SEC - 1);
  localparam logic [31:0] FreezeLast = 32'(HIT_FREEZE_SEC * TICKS_PER_SEC - 1);
  localparam logic [31:0] FlashLast  = 32'(FLASH_TICKS - 1);
  localparam logic [12:0] PixLast    = 13'd6143;
  localparam logic [1:0]  LivesInit  = 2'(LIVES_INIT);
  localparam logic [1:0]  CdInit     = 2'(COUNTDOWN_SEC);

  state_e      r_state, w_state_d;
  logic [31:0] r_tick, w_tick_d;
  logic [31:0] r_flash_cnt, w_flash_cnt_d;
  logic        r_blink, w_blink_d;
  logic        r_collide, w_collide_d;
  logic [1:0]  r_lives, w_lives_d;
  logic [1:0]  r_countdown, w_countdown_d;
  logic        r_hit_pulse, w_hit_pulse_d;
  logic        r_game_active, w_game_active_d;
  logic [15:0] r_oled, w_oled_d;
  logic        r_btn_prev;
  logic [12:0] r_pix_prev;

  logic w_start_edge;
  logic w_frame_end;
  logic w_coinc;
  logic w_collide_now;
  logic w_player_vis;

  assign w_start_edge  = bus.btnC_debounced && !r_btn_prev;
  assign w_frame_end   = (r_pix_prev == PixLast) && (bus.pixel_index != PixLast);
  assign w_coinc       = bus.is_player_hitbox && bus.is_obstacle;
  // A coincidence on the frame-end cycle itself still counts for that frame.
  assign w_collide_now = r_collide || w_coinc;

  always_comb begin
    w_state_d     = r_state;
    w_tick_d      = r_tick;
    w_flash_cnt_d = r_flash_cnt;
    w_blink_d     = r_blink;
    w_collide_d   = r_collide;
    w_lives_d     = r_lives;
    w_countdown_d = r_countdown;
    w_hit_pulse_d = 1'b0;

    unique case (r_state)
      StIdle, StGameOver: begin
        if (w_start_edge) begin
          w_state_d     = StCountdown;
          w_lives_d     = LivesInit;
          w_countdown_d = CdInit;
          w_tick_d      = '0;
        end
      end
      StCountdown: begin
        if (r_tick == TickLast) begin
          w_tick_d      = '0;
          w_countdown_d = r_countdown - 2'd1;
          if (r_countdown == 2'd1) begin
            w_state_d   = StActive;
            w_collide_d = 1'b0;
          end
        end else begin
          w_tick_d = r_tick + 32'd1;
        end
      end
      StActive: begin
        if (w_frame_end) begin
          w_collide_d = 1'b0;
          if (w_collide_now && (r_lives != 2'd0)) begin
            w_lives_d     = r_lives - 2'd1;
            w_hit_pulse_d = 1'b1;
            if (r_lives > 2'd1) begin
              w_state_d     = StHit;
              w_tick_d      = '0;
              w_flash_cnt_d = '0;
              w_blink_d     = 1'b0;
            end else begin
              w_state_d = StGameOver;
            end
          end
        end else begin
          w_collide_d = w_collide_now;
        end
      end
      StHit: begin
        if (r_tick == FreezeLast) begin
          w_state_d   = StActive;
          w_tick_d    = '0;
          w_collide_d = 1'b0;
        end else begin
          w_tick_d = r_tick + 32'd1;
        end
        if (r_flash_cnt == FlashLast) begin
          w_flash_cnt_d = '0;
          w_blink_d     = ~r_blink;
        end else begin
          w_flash_cnt_d = r_flash_cnt + 32'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_game_active_d = (w_state_d == StActive);
  end

  // Layer arbitration, registered from the current state and layer inputs.
  assign w_player_vis = (bus.oled_data_player != 16'd0) && !((r_state == StHit) && r_blink);

  always_comb begin
    w_oled_d = bus.oled_data_hud;
    unique case (r_state)
      StCountdown, StActive, StHit: begin
        if (w_player_vis) begin
          w_oled_d = bus.oled_data_player;
        end else if (bus.oled_data_obstacle != 16'd0) begin
          w_oled_d = bus.oled_data_obstacle;
        end
      end
      default: begin
        w_oled_d = bus.oled_data_hud;
      end
    endcase
  end

  always_ff @(posedge i_clock_100mhz) begin
    if (!i_reset_n) begin
      r_state       <= StIdle;
      r_tick        <= '0;
      r_flash_cnt   <= '0;
      r_blink       <= 1'b0;
      r_collide     <= 1'b0;
      r_lives       <= LivesInit;
      r_countdown   <= 2'd0;
      r_hit_pulse   <= 1'b0;
      r_game_active <= 1'b0;
      r_oled        <= 16'd0;
      // Treat the button as already pressed so a level held through reset is not a start.
      r_btn_prev    <= 1'b1;
      r_pix_prev    <= 13'd0;
    end else begin
      r_state       <= w_state_d;
      r_tick        <= w_tick_d;
      r_flash_cnt   <= w_flash_cnt_d;
      r_blink       <= w_blink_d;
      r_collide     <= w_collide_d;
      r_lives       <= w_lives_d;
      r_countdown   <= w_countdown_d;
      r_hit_pulse   <= w_hit_pulse_d;
      r_game_active <= w_game_active_d;
      r_oled        <= w_oled_d;
      r_btn_prev    <= bus.btnC_debounced;
      r_pix_prev    <= bus.pixel_index;
    end
  end

  assign bus.state       = r_state;
  assign bus.lives       = r_lives;
  assign bus.countdown   = r_countdown;
  assign bus.hit_pulse   = r_hit_pulse;
  assign bus.game_active = r_game_active;
  assign bus.oled_data   = r_oled;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl with short tick parameters.
module tb_game_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  game_ctrl_if u_if ();

  game_ctrl #(
    .TICKS_PER_SEC  (10),
    .COUNTDOWN_SEC  (3),
    .HIT_FREEZE_SEC (2),
    .FLASH_TICKS    (2),
    .LIVES_INIT     (3)
  ) u_dut (
    .i_clock_100mhz (clk),
    .i_reset_n      (rst_n),
    .bus            (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] st, input logic [1:0] lv,
                              input logic ga);
    check({tag, ".state"}, 16'(u_if.state), 16'(st));
    check({tag, ".lives"}, 16'(u_if.lives), 16'(lv));
    check({tag, ".game_active"}, 16'(u_if.game_active), 16'(ga));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    u_if.btnC_debounced     = 1'b0;
    u_if.pixel_index        = 13'd0;
    u_if.is_player_hitbox   = 1'b0;
    u_if.is_obstacle        = 1'b0;
    u_if.oled_data_player   = 16'h0000;
    u_if.oled_data_obstacle = 16'h0000;
    u_if.oled_data_hud      = 16'h001F;

    // Reset values
    step(2);
    check_status("rst", 3'd0, 2'd3, 1'b0);
    check("rst.countdown", 16'(u_if.countdown), 16'd0);
    check("rst.hit_pulse", 16'(u_if.hit_pulse), 16'd0);
    check("rst.oled", u_if.oled_data, 16'h0000);
    rst_n = 1'b1;
    step(1);
    check("idle.oled_hud", u_if.oled_data, 16'h001F);
    check("idle.state", 16'(u_if.state), 16'd0);

    // Start and countdown
    u_if.btnC_debounced = 1'b1;
    step(1);
    u_if.btnC_debounced = 1'b0;
    check_status("start", 3'd1, 2'd3, 1'b0);
    check("start.cd", 16'(u_if.countdown), 16'd3);
    step(9);
    check("cd9.cd", 16'(u_if.countdown), 16'd3);
    step(1);
    check("cd10.cd", 16'(u_if.countdown), 16'd2);
    step(10);
    check("cd20.cd", 16'(u_if.countdown), 16'd1);
    step(9);
    check_status("cd29", 3'd1, 2'd3, 1'b0);
    step(1);
    check_status("cd30", 3'd2, 2'd3, 1'b1);
    check("cd30.cd", 16'(u_if.countdown), 16'd0);

    // Arbitration in ACTIVE
    u_if.oled_data_player   = 16'hF800;
    u_if.oled_data_obstacle = 16'h07E0;
    step(1);
    check("arb.player", u_if.oled_data, 16'hF800);
    u_if.oled_data_player = 16'h0000;
    step(1);
    check("arb.obstacle", u_if.oled_data, 16'h07E0);
    u_if.oled_data_obstacle = 16'h0000;
    step(1);
    check("arb.hud", u_if.oled_data, 16'h001F);

    // Two collisions in one frame, then frame end
    u_if.pixel_index      = 13'd100;
    u_if.is_player_hitbox = 1'b1;
    u_if.is_obstacle      = 1'b1;
    step(1);
    u_if.is_player_hitbox = 1'b0;
    u_if.pixel_index      = 13'd200;
    step(1);
    u_if.is_player_hitbox = 1'b1;
    step(1);
    u_if.is_player_hitbox = 1'b0;
    u_if.is_obstacle      = 1'b0;
    u_if.pixel_index      = 13'd6143;
    step(1);
    check("pre_fe.hit_pulse", 16'(u_if.hit_pulse), 16'd0);
    check_status("pre_fe", 3'd2, 2'd3, 1'b1);
    u_if.pixel_index      = 13'd0;
    u_if.oled_data_player = 16'hF800;
    step(1);
    check("hit1.hit_pulse", 16'(u_if.hit_pulse), 16'd1);
    check_status("hit1", 3'd3, 2'd2, 1'b0);

    // Blink in HIT (FLASH_TICKS=2), collisions and a frame end during HIT are ignored
    step(1);
    check("hit1+1.hit_pulse", 16'(u_if.hit_pulse), 16'd0);
    check("blink1", u_if.oled_data, 16'hF800);
    u_if.is_player_hitbox = 1'b1;
    u_if.is_obstacle      = 1'b1;
    u_if.pixel_index      = 13'd6143;
    step(1);
    check("blink2", u_if.oled_data, 16'hF800);
    u_if.pixel_index = 13'd0;
    step(1);
    check("blink3", u_if.oled_data, 16'h001F);
    u_if.is_player_hitbox = 1'b0;
    u_if.is_obstacle      = 1'b0;
    step(1);
    check("blink4", u_if.oled_data, 16'h001F);
    step(1);
    check("blink5", u_if.oled_data, 16'hF800);
    check_status("hit_nodec", 3'd3, 2'd2, 1'b0);
    check("hit_nodec.hit_pulse", 16'(u_if.hit_pulse), 16'd0);
    step(14);
    check_status("freeze19", 3'd3, 2'd2, 1'b0);
    step(1);
    check_status("freeze20", 3'd2, 2'd2, 1'b1);

    // Frame end with no collision: no hit
    u_if.pixel_index = 13'd6143;
    step(1);
    u_if.pixel_index = 13'd0;
    step(1);
    check_status("fe_clean", 3'd2, 2'd2, 1'b1);
    check("fe_clean.hit_pulse", 16'(u_if.hit_pulse), 16'd0);

    // Second hit -> lives 1
    u_if.pixel_index      = 13'd6143;
    u_if.is_player_hitbox = 1'b1;
    u_if.is_obstacle      = 1'b1;
    step(1);
    u_if.pixel_index      = 13'd0;
    u_if.is_player_hitbox = 1'b0;
    u_if.is_obstacle      = 1'b0;
    step(1);
    check_status("hit2", 3'd3, 2'd1, 1'b0);
    step(20);
    check_status("hit2_done", 3'd2, 2'd1, 1'b1);

    // Coincidence exactly at frame end with a start edge on the same cycle
    u_if.pixel_index = 13'd6143;
    step(1);
    u_if.pixel_index      = 13'd0;
    u_if.is_player_hitbox = 1'b1;
    u_if.is_obstacle      = 1'b1;
    u_if.btnC_debounced   = 1'b1;
    step(1);
    u_if.is_player_hitbox = 1'b0;
    u_if.is_obstacle      = 1'b0;
    u_if.btnC_debounced   = 1'b0;
    check_status("over", 3'd4, 2'd0, 1'b0);
    check("over.hit_pulse", 16'(u_if.hit_pulse), 16'd1);
    step(1);
    check("over.oled_hud", u_if.oled_data, 16'h001F);
    check_status("over+1", 3'd4, 2'd0, 1'b0);

    // Restart from GAME_OVER
    u_if.btnC_debounced = 1'b1;
    step(1);
    u_if.btnC_debounced = 1'b0;
    check_status("restart", 3'd1, 2'd3, 1'b0);
    check("restart.cd", 16'(u_if.countdown), 16'd3);

    // Reset mid-countdown with button held through release
    step(5);
    rst_n               = 1'b0;
    u_if.btnC_debounced = 1'b1;
    step(1);
    check_status("rst_cd", 3'd0, 2'd3, 1'b0);
    check("rst_cd.cd", 16'(u_if.countdown), 16'd0);
    check("rst_cd.oled", u_if.oled_data, 16'h0000);
    rst_n = 1'b1;
    step(2);
    check("held_btn.state", 16'(u_if.state), 16'd0);
    u_if.btnC_debounced = 1'b0;
    step(1);
    check("released.state", 16'(u_if.state), 16'd0);
    u_if.btnC_debounced = 1'b1;
    step(1);
    u_if.btnC_debounced = 1'b0;
    check("repress.state", 16'(u_if.state), 16'd1);

    // Reset mid-HIT
    step(30);
    check_status("active3", 3'd2, 2'd3, 1'b1);
    u_if.pixel_index      = 13'd6143;
    u_if.is_player_hitbox = 1'b1;
    u_if.is_obstacle      = 1'b1;
    step(1);
    u_if.pixel_index      = 13'd0;
    u_if.is_player_hitbox = 1'b0;
    u_if.is_obstacle      = 1'b0;
    step(1);
    check_status("hit3", 3'd3, 2'd2, 1'b0);
    step(3);
    rst_n = 1'b0;
    step(1);
    check_status("rst_hit", 3'd0, 2'd3, 1'b0);
    check("rst_hit.hit_pulse", 16'(u_if.hit_pulse), 16'd0);
    check("rst_hit.oled", u_if.oled_data, 16'h0000);
    check("rst_hit.cd", 16'(u_if.countdown), 16'd0);
    rst_n = 1'b1;
    step(1);
    check("post_rst.state", 16'(u_if.state), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
